fetch_buffer: RTL and testbench

- Instruction prefetch unit directly upstream of the IF stage of the pipelined CPU.
- Generates sequential PCs and issues requests to a variable-latency instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small FIFO and presents {instr, instr_pc} to IF.
- Handles branch redirects by flushing the FIFO and draining stale in-flight responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_buffer.sv | 138 +++++++++++++
 tb/tb_fetch_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, reset address and types for the instruction prefetch buffer.
package fetch_pkg;

    localparam int                      FETCH_PC_W     = 64;
    localparam int                      FETCH_INSTR_W  = 32;
    localparam logic [FETCH_PC_W-1:0]   FETCH_RESET_PC = 64'h0;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush wins over push and pop,
// and a push into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is never presented before it is written.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch unit: credit-limited sequential fetch into a FIFO, redirect flush
// with stale-response draining. Define FETCH_BYPASS_EN for a 0-cycle empty-FIFO bypass.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = FETCH_PC_W,
    parameter int              INSTR_W  = FETCH_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [PC_W-1:0]  target_pc;
    logic [CNT_W-1:0] occupancy;
    logic             accept, rsp_ok, keep, bypass;
    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    entry_t           fifo_head;
    logic             unused_pc_bits;

    assign target_pc      = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    assign imem_req_valid = reset && (state_q == FETCH) &&
                            ((SUM_W'(occupancy) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is otherwise ignored.
    assign rsp_ok = imem_rsp_valid && (outstanding_q != '0);
    assign keep   = rsp_ok && !redirect && (discard_q == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && (state_q == FETCH) && (discard_q == '0) && rsp_ok;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = !redirect && (!fifo_empty || bypass);
    assign fifo_pop    = instr_valid && !stall;
    assign fifo_push   = keep && !(bypass && !stall);

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (instr_valid) begin
            if (fifo_empty) begin
                instr    = imem_rsp_data;
                instr_pc = resp_pc_q;
            end else begin
                instr    = fifo_head.instr;
                instr_pc = fifo_head.pc;
            end
        end
    end

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp_ok);
        fetch_pc_d    = accept ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
        resp_pc_d     = keep ? resp_pc_q + PC_W'(4) : resp_pc_q;
        discard_d     = (rsp_ok && discard_q != '0) ? discard_q - 1'b1 : discard_q;
        state_d       = state_q;
        if (redirect) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            discard_d  = outstanding_d;
            state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
        end else if (state_q == DRAIN && discard_d == '0) begin
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_ni      (reset),
        .flush_i     (redirect),
        .push_i      (fifo_push),
        .push_data_i ({imem_rsp_data, resp_pc_q}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (occupancy)
    );

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (outstanding_q != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (fifo_push && fifo_full) |-> fifo_pop);

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: memory model with fixed latency, a queue-based
// reference model compared every negedge, and directed scenarios with literal expectations.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    always #5 clk = ~clk;

    fetch_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Instruction memory: every accepted request answers exactly `lat` cycles later.
    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    cyc = 0;
    int    lat = 1;
    int    n_acc = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Reference model: FIFO contents as a queue, in-flight and to-be-dropped as plain counts.
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ment_t;
    ment_t       m_q[$];
    int          m_out = 0;
    int          m_disc = 0;
    bit          m_drain = 1'b0;
    logic [63:0] m_fpc = '0;
    logic [63:0] m_rpc = '0;

    always @(negedge clk) begin : cmp
        bit          e_req, e_valid, byp, acc, rsp, pop;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        if (!reset) begin
            check("req_valid_in_reset", imem_req_valid, 1'b0);
            m_q.delete();
            m_out   = 0;
            m_disc  = 0;
            m_drain = 1'b0;
            m_fpc   = '0;
            m_rpc   = '0;
        end else begin
            rsp     = imem_rsp_valid && (m_out > 0);
            e_req   = !m_drain && (m_q.size() + m_out < DEPTH);
            byp     = BYP && (m_q.size() == 0) && !m_drain && (m_disc == 0) && rsp;
            e_valid = !redirect && (m_q.size() > 0 || byp);
            e_instr = '0;
            e_pc    = '0;
            if (e_valid) begin
                if (m_q.size() > 0) begin
                    e_instr = m_q[0].instr;
                    e_pc    = m_q[0].pc;
                end else begin
                    e_instr = mem_word(m_rpc);
                    e_pc    = m_rpc;
                end
            end
            check("req_valid", imem_req_valid, e_req);
            if (e_req) check("req_addr", imem_req_addr, m_fpc);
            check("instr_valid", instr_valid, e_valid);
            check("instr", instr, e_instr);
            check("instr_pc", instr_pc, e_pc);

            acc = e_req && imem_req_ready;
            pop = e_valid && !stall;
            if (redirect) begin
                m_q.delete();
                m_out   = m_out + int'(acc) - int'(rsp);
                m_disc  = m_out;
                m_drain = (m_disc != 0);
                m_fpc   = {redirect_pc[63:2], 2'b00};
                m_rpc   = {redirect_pc[63:2], 2'b00};
            end else begin
                m_out = m_out + int'(acc) - int'(rsp);
                if (acc) m_fpc = m_fpc + 64'd4;
                if (pop && m_q.size() > 0) void'(m_q.pop_front());
                if (rsp) begin
                    if (m_disc > 0) begin
                        m_disc--;
                    end else begin
                        if (!(byp && !stall)) m_q.push_back({mem_word(m_rpc), m_rpc});
                        m_rpc = m_rpc + 64'd4;
                    end
                end
                if (m_disc == 0) m_drain = 1'b0;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{imem_req_addr, cyc + lat});
            n_acc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset long enough for every in-flight response to land while it is low.
    task automatic do_reset(input int new_lat);
        reset          = 1'b0;
        redirect       = 1'b0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        repeat (6) next_cycle();
        lat   = new_lat;
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < budget) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        check({name, "_valid_within_budget"}, instr_valid, 1'b1);
    endtask

    initial begin
        int base;

        // Sequential fetch, 1-cycle memory.
        do_reset(1);
        @(negedge clk);
        check("t1_first_req_valid", imem_req_valid, 1'b1);
        check("t1_first_req_addr", imem_req_addr, 64'h0);
        next_cycle();
        @(negedge clk);
        check("t1_rsp_to_valid_latency", instr_valid, BYP);
        next_cycle();
        @(negedge clk);
        check("t1_pc_cycle2", instr_pc, BYP ? 64'h4 : 64'h0);
        check("t1_instr_cycle2", instr, BYP ? 64'hC0DE_0004 : 64'hC0DE_0000);
        next_cycle();
        @(negedge clk);
        check("t1_pc_cycle3", instr_pc, BYP ? 64'h8 : 64'h4);
        repeat (6) next_cycle();

        // Stall from reset release: credit limit stops requests at DEPTH.
        do_reset(1);
        stall = 1'b1;
        base  = n_acc;
        repeat (10) next_cycle();
        @(negedge clk);
        check("t2_req_count", 64'(n_acc - base), 64'd4);
        check("t2_req_dropped", imem_req_valid, 1'b0);
        check("t2_head_pc", instr_pc, 64'h0);
        next_cycle();
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_release_order", instr_pc, 64'(4 * i));
            next_cycle();
        end
        repeat (4) next_cycle();

        // Redirect with 3 in flight on a 3-cycle memory; same-cycle accept and response.
        do_reset(3);
        repeat (3) next_cycle();
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        next_cycle();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_drain_no_req", imem_req_valid, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        check("t3_restart_req_valid", imem_req_valid, 1'b1);
        check("t3_restart_addr", imem_req_addr, 64'h100);
        wait_valid("t3", 20);
        check("t3_first_pc", instr_pc, 64'h100);
        repeat (4) next_cycle();

        // Redirect while streaming: pending pop cancelled, accepted request discarded.
        do_reset(1);
        repeat (5) next_cycle();
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        @(negedge clk);
        check("t4_valid_cancelled", instr_valid, 1'b0);
        check("t4_accept_in_redirect", imem_req_valid, 1'b1);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("t4_drain_no_req", imem_req_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("t4_restart_addr", imem_req_addr, 64'h200);
        wait_valid("t4", 10);
        check("t4_first_pc", instr_pc, 64'h200);
        repeat (4) next_cycle();

        // Second redirect while already draining.
        do_reset(3);
        repeat (3) next_cycle();
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        next_cycle();
        redirect = 1'b0;
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 64'h402;
        next_cycle();
        redirect = 1'b0;
        wait_valid("t5", 20);
        check("t5_first_pc", instr_pc, 64'h400);
        repeat (4) next_cycle();

        // Reset with two responses in flight.
        do_reset(3);
        repeat (2) next_cycle();
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        check("t6_valid_zero", instr_valid, 1'b0);
        check("t6_instr_zero", instr, 64'h0);
        check("t6_pc_zero", instr_pc, 64'h0);
        do_reset(3);
        @(negedge clk);
        check("t6_restart_addr", imem_req_addr, 64'h0);
        wait_valid("t6", 20);
        check("t6_first_pc", instr_pc, 64'h0);
        repeat (4) next_cycle();

        // Mixed ready/stall pattern with a redirect in the middle.
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            imem_req_ready = (i % 3) != 2;
            stall          = (i % 5) == 3;
            redirect       = (i == 25);
            redirect_pc    = 64'h1000;
            next_cycle();
        end
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        repeat (10) next_cycle();

        // PC wraps modulo 2^64.
        do_reset(1);
        repeat (2) next_cycle();
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
        next_cycle();
        redirect = 1'b0;
        wait_valid("t8", 10);
        check("t8_pc_fff8", instr_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        next_cycle();
        @(negedge clk);
        check("t8_pc_fffc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        next_cycle();
        @(negedge clk);
        check("t8_pc_wrap", instr_pc, 64'h0);
        repeat (3) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
